acc_bcd_display: RTL and testbench
==================================

Name: acc_bcd_display

Overview:
- Sequential binary-to-BCD converter and seven-segment driver for the accumulator's result.
- Takes the 8-bit unsigned accumulator value plus its overflow flag and converts it with a shift-add-3 (double-dabble) state machine, one bit per clock.
- Drives three active-low seven-segment displays: hundreds, tens and units.
- Sits between the accumulator output (out/overflow) and the board HEX outputs.

Parameters:
WIDTH, 8, width of the binary input value; the number of shift cycles per conversion.
DIGITS, 3, number of BCD digits produced; the output bcd bus is 4*DIGITS wide.

Ports:
clk  input  1  system clock, rising-edge.
clr  input  1  reset, asynchronous, active-low.
start  input  1  request a conversion; sampled only in IDLE.
value  input  WIDTH  unsigned binary value to convert.
ovf_in  input  1  overflow flag accompanying value.
busy  output  1  high while a conversion is in progress.
done  output  1  single-cycle pulse when a conversion completes.
bcd  output  4*DIGITS  packed BCD result: [3:0] units, [7:4] tens, [11:8] hundreds.
hex0  output  7  units display, active-low, bit0=a through bit6=g.
hex1  output  7  tens display, same encoding.
hex2  output  7  hundreds display, same encoding.

Behaviour:
- Reset (clr=0, asynchronous):
  - state=IDLE; busy=0; done=0; bcd=0; latched overflow=0; shift counter=0; scratch registers=0.
  - hex0/hex1/hex2 = 7'b1000000 (digit "0").
- States: IDLE, SHIFT, FINISH.
- IDLE:
  - If start=1 at a rising edge: latch value into the shift register and ovf_in into ovf_q.
  - Clear the BCD scratch, load counter=WIDTH, set busy=1, go to SHIFT.
  - If start=0: remain in IDLE.
- SHIFT, each edge:
  - Every scratch nibble >=5 gets +3.
  - Then {scratch, shiftreg} shifts left by 1.
  - Counter decrements; when it reaches 0, go to FINISH.
  - Exactly WIDTH shift edges are performed.
- FINISH, one edge:
  - Copy scratch to bcd and copy ovf_q to the display-overflow register.
  - Assert done=1 for exactly one cycle, set busy=0, return to IDLE.
- Latency: with start sampled at edge t, shifts occur at edges t+1..t+WIDTH and FINISH at edge t+WIDTH+1. done is high for the cycle after edge t+WIDTH+1. busy is high from after edge t until that edge.
- start while busy (SHIFT or FINISH): ignored and not queued. Changes to value/ovf_in during a conversion are ignored because the inputs are latched at start.
- start in the same cycle FINISH completes: ignored. A new start is accepted only when the state is IDLE at the sampling edge.
- Outputs bcd/hex hold the last completed result until the next FINISH. They never show partial results.
- Display decode (combinational from registered bcd and the display-overflow register):
  - Digits 0-9 use standard active-low patterns: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
  - Nibble >9 (unreachable) = 1111111 (blank).
  - If the display-overflow register is 1, all three displays show "-" (0111111). bcd still holds the converted value.
- Arithmetic: with WIDTH=8 the maximum is 255, so the hundreds nibble is <=2. No carry out of the top nibble is possible at the default parameters.
- Reset asserted mid-conversion aborts immediately to the reset state. No done pulse is produced.

Test Plan:
- Reset, then value=8'd255, ovf_in=0, start for 1 cycle -> busy for WIDTH+1 cycles; done pulse after edge t+9; bcd=12'h255; hex2=0100100, hex1=0010010, hex0=0010010.
- value=8'd0, start -> bcd=12'h000, all hex=1000000. Then value=8'd100, start -> bcd=12'h100; hex2=1111001, hex1=1000000, hex0=1000000.
- Start with value=8'd37; at cycle 3 change value to 8'd200 and pulse start again -> second start ignored, single done, bcd=12'h037.
- value=8'd9, ovf_in=1, start -> bcd=12'h009; hex0/hex1/hex2 all 0111111. Next conversion with ovf_in=0, value=8'd9 -> hex0=0010000.
- Start with value=8'd128, drop clr at cycle 4 -> busy=0 and bcd=0 immediately, no done. Release clr and restart -> bcd=12'h128.
- Back-to-back: hold start high continuously with value=8'd42 -> conversions complete every WIDTH+2 cycles, each giving bcd=12'h042 with a one-cycle done.

Source files
------------

// File: rtl/acc_bcd_display.sv
// Sequential binary-to-BCD converter (shift-add-3, one bit per clock) driving
// three active-low seven-segment displays for the accumulator result.
module acc_bcd_display #(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  clr,
  input  logic                  start,
  input  logic [WIDTH-1:0]      value,
  input  logic                  ovf_in,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd,
  output logic [6:0]            hex0,
  output logic [6:0]            hex1,
  output logic [6:0]            hex2
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, SHIFT, FINISH} state_t;

  state_t              state, state_nxt;
  logic [WIDTH-1:0]    shift_q;
  logic [4*DIGITS-1:0] scratch_q;
  logic [4*DIGITS-1:0] scratch_adj;
  logic [CW-1:0]       cnt_q;
  logic                ovf_q;
  logic                disp_ovf_q;

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'b1000000;
      4'd1:    seg7 = 7'b1111001;
      4'd2:    seg7 = 7'b0100100;
      4'd3:    seg7 = 7'b0110000;
      4'd4:    seg7 = 7'b0011001;
      4'd5:    seg7 = 7'b0010010;
      4'd6:    seg7 = 7'b0000010;
      4'd7:    seg7 = 7'b1111000;
      4'd8:    seg7 = 7'b0000000;
      4'd9:    seg7 = 7'b0010000;
      default: seg7 = 7'b1111111;
    endcase
  endfunction

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = SHIFT;
      SHIFT:   if (cnt_q == CW'(1)) state_nxt = FINISH;
      FINISH:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = (state != IDLE);
    hex0 = disp_ovf_q ? 7'b0111111 : seg7(bcd[3:0]);
    hex1 = disp_ovf_q ? 7'b0111111 : seg7(bcd[7:4]);
    hex2 = disp_ovf_q ? 7'b0111111 : seg7(bcd[11:8]);
  end

  // Add 3 to every nibble that would reach 10 or more after the next doubling.
  always_comb begin
    scratch_adj = scratch_q;
    for (int i = 0; i < DIGITS; i++) begin
      if (scratch_q[4*i +: 4] >= 4'd5)
        scratch_adj[4*i +: 4] = scratch_q[4*i +: 4] + 4'd3;
    end
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      shift_q    <= '0;
      scratch_q  <= '0;
      cnt_q      <= '0;
      ovf_q      <= 1'b0;
      disp_ovf_q <= 1'b0;
      bcd        <= '0;
      done       <= 1'b0;
    end else begin
      done <= (state == FINISH);
      case (state)
        IDLE: begin
          if (start) begin
            shift_q   <= value;
            ovf_q     <= ovf_in;
            scratch_q <= '0;
            cnt_q     <= CW'(WIDTH);
          end
        end
        SHIFT: begin
          {scratch_q, shift_q} <= {scratch_adj, shift_q} << 1;
          cnt_q                <= cnt_q - CW'(1);
        end
        FINISH: begin
          bcd        <= scratch_q;
          disp_ovf_q <= ovf_q;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_acc_bcd_display.sv
// Self-checking bench for acc_bcd_display: directed cases plus random
// conversions compared against a decimal-arithmetic reference model.
module tb_acc_bcd_display;

  localparam int WIDTH  = 8;
  localparam int DIGITS = 3;

  logic             clk = 1'b0;
  logic             clr = 1'b0;
  logic             start = 1'b0;
  logic [WIDTH-1:0] value = '0;
  logic             ovf_in = 1'b0;
  logic             busy, done;
  logic [11:0]      bcd;
  logic [6:0]       hex0, hex1, hex2;

  int total = 0;
  int bad   = 0;

  logic [6:0] seg_tab [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                               7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                               7'b0000000, 7'b0010000};

  acc_bcd_display #(.WIDTH(WIDTH), .DIGITS(DIGITS)) dut (
    .clk(clk), .clr(clr), .start(start), .value(value), .ovf_in(ovf_in),
    .busy(busy), .done(done), .bcd(bcd), .hex0(hex0), .hex1(hex1), .hex2(hex2)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [11:0] model_bcd(input int v);
    return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  function automatic logic [6:0] model_hex(input int digit, input logic ovf);
    return ovf ? 7'b0111111 : seg_tab[digit];
  endfunction

  task automatic checkDisplay(input string tag, input int v, input logic ovf);
    checkOutput({tag, " bcd"},  16'(bcd),  16'(model_bcd(v)));
    checkOutput({tag, " hex0"}, 16'(hex0), 16'(model_hex(v % 10, ovf)));
    checkOutput({tag, " hex1"}, 16'(hex1), 16'(model_hex((v / 10) % 10, ovf)));
    checkOutput({tag, " hex2"}, 16'(hex2), 16'(model_hex(v / 100, ovf)));
  endtask

  // Pulse start for one edge, then follow the conversion until done (bounded).
  task automatic applyStimulus(input string tag, input int v, input logic ovf);
    int n, busy_n;
    value  = WIDTH'(v);
    ovf_in = ovf;
    start  = 1'b1;
    step();
    start  = 1'b0;
    n = 0;
    busy_n = 0;
    while (!done && n < 30) begin
      if (busy) busy_n++;
      step();
      n++;
    end
    checkOutput({tag, " latency"}, 16'(n), 16'(WIDTH + 1));
    checkOutput({tag, " busy cycles"}, 16'(busy_n), 16'(WIDTH + 1));
    checkOutput({tag, " busy at done"}, 16'(busy), 16'h0);
    checkDisplay(tag, v, ovf);
    step();
    checkOutput({tag, " done width"}, 16'(done), 16'h0);
  endtask

  initial begin
    int v, n, ndone, last;
    logic o;

    #2;
    checkOutput("reset busy", 16'(busy), 16'h0);
    checkOutput("reset done", 16'(done), 16'h0);
    checkDisplay("reset", 0, 1'b0);
    step();
    clr = 1'b1;
    step();

    applyStimulus("v255", 255, 1'b0);
    applyStimulus("v0", 0, 1'b0);
    applyStimulus("v100", 100, 1'b0);

    // Second start during SHIFT must be ignored, not queued.
    value = 8'd37; ovf_in = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    step(); step();
    value = 8'd200; start = 1'b1;
    step();
    start = 1'b0;
    ndone = 0;
    for (int i = 0; i < 25; i++) begin
      if (done) begin
        ndone++;
        checkDisplay("overlap", 37, 1'b0);
      end
      step();
    end
    checkOutput("overlap done count", 16'(ndone), 16'h1);

    applyStimulus("v9 ovf", 9, 1'b1);
    applyStimulus("v9 clean", 9, 1'b0);

    // Reset in the middle of a conversion aborts with no done pulse.
    value = 8'd128; start = 1'b1;
    step();
    start = 1'b0;
    step(); step(); step();
    #2 clr = 1'b0;
    #1;
    checkOutput("abort busy", 16'(busy), 16'h0);
    checkOutput("abort done", 16'(done), 16'h0);
    checkDisplay("abort", 0, 1'b0);
    step();
    clr = 1'b1;
    ndone = 0;
    for (int i = 0; i < 15; i++) begin
      if (done || busy) ndone++;
      step();
    end
    checkOutput("abort no activity", 16'(ndone), 16'h0);
    applyStimulus("v128", 128, 1'b0);

    // start held high: a conversion every WIDTH+2 cycles.
    value = 8'd42; ovf_in = 1'b0; start = 1'b1;
    ndone = 0;
    last = -1;
    for (int i = 0; i < 50; i++) begin
      step();
      if (done) begin
        if (last >= 0) checkOutput("b2b period", 16'(i - last), 16'(WIDTH + 2));
        checkDisplay("b2b", 42, 1'b0);
        last = i;
        ndone++;
      end
    end
    checkOutput("b2b done count", 16'(ndone), 16'h5);
    start = 1'b0;
    n = 0;
    while (busy && n < 20) begin
      step();
      n++;
    end
    checkOutput("b2b drained", 16'(busy), 16'h0);
    step();

    for (int k = 0; k < 20; k++) begin
      v = int'($urandom_range(0, 255));
      o = ($urandom_range(0, 3) == 0);
      applyStimulus($sformatf("rand%0d", k), v, o);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

endmodule
